// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer: opcodes, FSM states,
// datapath select encodings and the immediate-format lookup.
package multicycle_ctrl_pkg;

  // Opcodes understood by the sequencer
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Branch comparison selectors (funct3)
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  // Coarse ALU intent handed to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Immediate format implied by an opcode; unknown opcodes fall back to I
  function automatic imm_src_t imm_src_of(input logic [6:0] opcode);
    imm_src_t fmt;
    case (opcode)
      OP_STORE:  fmt = IMM_S;
      OP_BRANCH: fmt = IMM_B;
      OP_JAL:    fmt = IMM_J;
      OP_LUI:    fmt = IMM_U;
      default:   fmt = IMM_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the sequencer (master) and the datapath/memory (slave).
interface multicycle_ctrl_if;
  import multicycle_ctrl_pkg::*;

  // Status from the datapath and memory
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;

  // Controls toward the datapath and memory
  logic        mem_req;
  logic        mem_write;
  logic        addr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  result_src;
  logic [2:0]  imm_src;
  logic [2:0]  alu_ctrl;
  logic        illegal_op;

  modport master (
    input  instr, zero, mem_ready,
    output mem_req, mem_write, addr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_op
  );

  modport slave (
    output instr, zero, mem_ready,
    input  mem_req, mem_write, addr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_op
  );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the sequencer's coarse ALU intent plus funct fields to an ALU operation.
module multicycle_ctrl_alu_decoder
  import multicycle_ctrl_pkg::*;
(
  input  alu_op_t    alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output alu_ctrl_t  alu_ctrl_o
);

  // Only R-type (op5=1) may turn funct3=000 into a subtract; addi ignores bit 30
  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_ctrl_o = ALU_ADD;
      ALUOP_SUB: alu_ctrl_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_ctrl_o = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b111:  alu_ctrl_o = ALU_AND;
          3'b110:  alu_ctrl_o = ALU_OR;
          3'b010:  alu_ctrl_o = ALU_SLT;
          default: alu_ctrl_o = ALU_ADD;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencer of the multi-cycle RV32I core. One ALU and one memory port are
// shared across FETCH/DECODE/EXECUTE/MEM/WRITEBACK; every datapath enable and
// select is decoded here from the current state (plus a few live inputs).
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int RESET_VEC_HOLD = 1  // idle FETCH cycles after reset (0..3)
) (
  input  logic              clk,
  input  logic              rst,
  multicycle_ctrl_if.master bus
);

  localparam logic [1:0] HOLD_INIT = 2'(RESET_VEC_HOLD);

  // Instruction fields used for sequencing
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       unused_instr_bits;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7b5 = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  // State and post-reset hold counter
  state_t     state_q, state_d;
  logic [1:0] hold_q, hold_d;
  logic       holding;

  assign holding = (hold_q != 2'd0);

  // Control outputs before they reach the interface
  logic        mem_req;
  logic        mem_write;
  logic        addr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic        illegal_op;
  src_a_t      alu_src_a;
  src_b_t      alu_src_b;
  result_src_t result_src;
  imm_src_t    imm_src;
  alu_op_t     alu_op;
  alu_ctrl_t   alu_ctrl;
  logic        branch_taken;

  multicycle_ctrl_alu_decoder u_alu_decoder (
    .alu_op_i   (alu_op),
    .funct3_i   (funct3),
    .funct7b5_i (funct7b5),
    .op5_i      (opcode[5]),
    .alu_ctrl_o (alu_ctrl)
  );

  // State register and hold counter; reset reloads the hold so fetch restarts cleanly
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      hold_q  <= HOLD_INIT;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // Branch resolution from the subtract result; unsupported compares never redirect
  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:  branch_taken = bus.zero;
      F3_BNE:  branch_taken = !bus.zero;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state logic; memory states wait for mem_ready so the request is never withdrawn
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_FETCH: begin
        if (holding) begin
          hold_d = hold_q - 2'd1;
        end else if (bus.mem_ready) begin
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; all-zero encodings are the idle values, so reset simply skips the decode
  always_comb begin
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    illegal_op = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    result_src = RES_ALUOUT;
    imm_src    = IMM_I;
    alu_op     = ALUOP_ADD;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          // PC+4 is presented live so the PC can update in the same cycle as the IR
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALURESULT;
          if (!holding) begin
            mem_req  = 1'b1;
            ir_write = bus.mem_ready;
            pc_write = bus.mem_ready;
          end
        end
        S_DECODE: begin
          // Speculative branch/jump target old_pc+imm lands in ALUOut
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_IMM;
          imm_src    = imm_src_of(opcode);
          case (opcode)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE,
            OP_BRANCH, OP_JAL, OP_LUI: illegal_op = 1'b0;
            default:                   illegal_op = 1'b1;
          endcase
        end
        S_MEMADR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = imm_src_of(opcode);
        end
        S_MEMREAD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
        end
        S_MEMWB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req   = 1'b1;
          mem_write = 1'b1;
          addr_src  = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          alu_op    = ALUOP_FUNCT;
        end
        S_EXECI: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_I;
          alu_op    = ALUOP_FUNCT;
        end
        S_ALUWB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
        S_BRANCH: begin
          // Compare rs1-rs2 while ALUOut still holds the target
          alu_src_a  = SRCA_RS1;
          alu_src_b  = SRCB_RS2;
          alu_op     = ALUOP_SUB;
          result_src = RES_ALUOUT;
          pc_write   = branch_taken;
        end
        S_JAL: begin
          // Jump to the target in ALUOut while the ALU forms the link address
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALUOUT;
          pc_write   = 1'b1;
        end
        S_LUI: begin
          alu_src_a = SRCA_ZERO;
          alu_src_b = SRCB_IMM;
          imm_src   = IMM_U;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Drive the interface
  assign bus.mem_req    = mem_req;
  assign bus.mem_write  = mem_write;
  assign bus.addr_src   = addr_src;
  assign bus.ir_write   = ir_write;
  assign bus.pc_write   = pc_write;
  assign bus.reg_write  = reg_write;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.result_src = result_src;
  assign bus.imm_src    = imm_src;
  assign bus.alu_ctrl   = alu_ctrl;
  assign bus.illegal_op = illegal_op;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: every cycle the expected control word is
// queued when the inputs are driven and checked against the outputs at negedge.
module tb_multicycle_ctrl;

  logic clk;
  logic rst;

  multicycle_ctrl_if ifc ();

  multicycle_ctrl #(
    .RESET_VEC_HOLD (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [20:0] exp_q [$];
  string       tag_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          txn_cycles = 0;

  // Control word layout: req wr asrc irw pcw rw | sa sb rs | imm alu | ill
  function automatic logic [20:0] cw(input logic req, input logic wr, input logic asrc,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] rs, input logic [2:0] imm,
                                     input logic [2:0] alu, input logic ill);
    return {req, wr, asrc, irw, pcw, rw, sa, sb, rs, imm, alu, ill};
  endfunction

  function automatic logic [20:0] obs_word();
    return {ifc.mem_req, ifc.mem_write, ifc.addr_src, ifc.ir_write, ifc.pc_write,
            ifc.reg_write, ifc.alu_src_a, ifc.alu_src_b, ifc.result_src,
            ifc.imm_src, ifc.alu_ctrl, ifc.illegal_op};
  endfunction

  // Expected words per step, written from the control table
  function automatic logic [20:0] e_hold();
    return cw(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_fetch(input logic rdy);
    return cw(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_decode(input logic [2:0] imm, input logic ill);
    return cw(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 2'b00, imm, 3'b000, ill);
  endfunction
  function automatic logic [20:0] e_execi(input logic [2:0] alu);
    return cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, 3'b000, alu, 0);
  endfunction
  function automatic logic [20:0] e_execr(input logic [2:0] alu);
    return cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b00, 3'b000, alu, 0);
  endfunction
  function automatic logic [20:0] e_aluwb();
    return cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_branch(input logic pcw);
    return cw(0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 2'b00, 3'b000, 3'b001, 0);
  endfunction
  function automatic logic [20:0] e_memadr(input logic [2:0] imm);
    return cw(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b00, imm, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_memread();
    return cw(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_memwb();
    return cw(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b01, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_memwrite();
    return cw(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_jal();
    return cw(0, 0, 0, 0, 1, 0, 2'b01, 2'b10, 2'b00, 3'b000, 3'b000, 0);
  endfunction
  function automatic logic [20:0] e_lui();
    return cw(0, 0, 0, 0, 0, 0, 2'b11, 2'b01, 2'b00, 3'b100, 3'b000, 0);
  endfunction

  // Pop the oldest expectation and compare with the live outputs
  task automatic check_out();
    logic [20:0] exp_w;
    logic [20:0] obs_w;
    string       tag;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $error("FAIL sb_underflow: observed empty queue expected an entry");
    end else begin
      exp_w = exp_q.pop_front();
      tag   = tag_q.pop_front();
      obs_w = obs_word();
      assert (obs_w === exp_w) else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", tag, obs_w, exp_w);
      end
    end
  endtask

  // One clock: drive inputs, queue the expectation, check at negedge
  task automatic cyc(input string tag, input logic r, input logic rdy, input logic z,
                     input logic [20:0] exp_w);
    rst           = r;
    ifc.mem_ready = rdy;
    ifc.zero      = z;
    exp_q.push_back(exp_w);
    tag_q.push_back(tag);
    txn_cycles++;
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_txn(input logic [31:0] ins);
    ifc.instr  = ins;
    txn_cycles = 0;
  endtask

  task automatic end_txn(input string name);
    $display("txn %-8s instr=%h cycles=%0d", name, ifc.instr, txn_cycles);
  endtask

  task automatic alu_txn(input string name, input logic [31:0] ins, input logic is_r,
                         input logic [2:0] alu);
    begin_txn(ins);
    cyc({name, ".fetch"},  0, 1, 0, e_fetch(1));
    cyc({name, ".decode"}, 0, 1, 0, e_decode(3'b000, 0));
    cyc({name, ".exec"},   0, 1, 0, is_r ? e_execr(alu) : e_execi(alu));
    cyc({name, ".wb"},     0, 1, 0, e_aluwb());
    end_txn(name);
  endtask

  task automatic br_txn(input string name, input logic [31:0] ins, input logic z,
                        input logic pcw);
    begin_txn(ins);
    cyc({name, ".fetch"},  0, 1, z, e_fetch(1));
    cyc({name, ".decode"}, 0, 1, z, e_decode(3'b010, 0));
    cyc({name, ".branch"}, 0, 1, z, e_branch(pcw));
    end_txn(name);
  endtask

  initial begin
    rst           = 1'b1;
    ifc.instr     = 32'h0;
    ifc.zero      = 1'b0;
    ifc.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset for two cycles with mem_ready high: everything must stay quiet
    cyc("rst0", 1, 1, 0, '0);
    cyc("rst1", 1, 1, 0, '0);

    // addi x1,x0,5 after the one-cycle reset hold
    begin_txn(32'h00500093);
    cyc("addi.hold",   0, 1, 0, e_hold());
    cyc("addi.fetch",  0, 1, 0, e_fetch(1));
    cyc("addi.decode", 0, 1, 0, e_decode(3'b000, 0));
    cyc("addi.exec",   0, 1, 0, e_execi(3'b000));
    cyc("addi.wb",     0, 1, 0, e_aluwb());
    end_txn("addi");

    // sub x3,x1,x2 with three stalled fetch cycles
    begin_txn(32'h402081B3);
    cyc("sub.stall0", 0, 0, 0, e_fetch(0));
    cyc("sub.stall1", 0, 0, 0, e_fetch(0));
    cyc("sub.stall2", 0, 0, 0, e_fetch(0));
    cyc("sub.fetch",  0, 1, 0, e_fetch(1));
    cyc("sub.decode", 0, 1, 0, e_decode(3'b000, 0));
    cyc("sub.exec",   0, 1, 0, e_execr(3'b001));
    cyc("sub.wb",     0, 1, 0, e_aluwb());
    end_txn("sub");

    // ALU decoder coverage
    alu_txn("or",    32'h0020E1B3, 1, 3'b011);
    alu_txn("sll",   32'h002091B3, 1, 3'b000);
    alu_txn("andi",  32'h0070F093, 0, 3'b010);
    alu_txn("slti",  32'h0020A093, 0, 3'b101);
    alu_txn("addi30",32'h40000093, 0, 3'b000);

    // Branches: taken/not-taken for bne and beq, blt never writes
    br_txn("bne.z0", 32'h00209463, 0, 1);
    br_txn("bne.z1", 32'h00209463, 1, 0);
    br_txn("beq.z1", 32'h00208463, 1, 1);
    br_txn("beq.z0", 32'h00208463, 0, 0);
    br_txn("blt.z1", 32'h0020C463, 1, 0);

    // lw x3,0(x1) with one slow memory cycle
    begin_txn(32'h0000A183);
    cyc("lw.fetch",  0, 1, 0, e_fetch(1));
    cyc("lw.decode", 0, 1, 0, e_decode(3'b000, 0));
    cyc("lw.memadr", 0, 1, 0, e_memadr(3'b000));
    cyc("lw.rdwait", 0, 0, 0, e_memread());
    cyc("lw.rd",     0, 1, 0, e_memread());
    cyc("lw.wb",     0, 1, 0, e_memwb());
    end_txn("lw");

    // sw x2,4(x1)
    begin_txn(32'h0020A223);
    cyc("sw.fetch",  0, 1, 0, e_fetch(1));
    cyc("sw.decode", 0, 1, 0, e_decode(3'b001, 0));
    cyc("sw.memadr", 0, 1, 0, e_memadr(3'b001));
    cyc("sw.wr",     0, 1, 0, e_memwrite());
    end_txn("sw");

    // jal x1,0
    begin_txn(32'h000000EF);
    cyc("jal.fetch",  0, 1, 0, e_fetch(1));
    cyc("jal.decode", 0, 1, 0, e_decode(3'b011, 0));
    cyc("jal.jump",   0, 1, 0, e_jal());
    cyc("jal.wb",     0, 1, 0, e_aluwb());
    end_txn("jal");

    // lui x5,0x12345
    begin_txn(32'h123452B7);
    cyc("lui.fetch",  0, 1, 0, e_fetch(1));
    cyc("lui.decode", 0, 1, 0, e_decode(3'b100, 0));
    cyc("lui.exec",   0, 1, 0, e_lui());
    cyc("lui.wb",     0, 1, 0, e_aluwb());
    end_txn("lui");

    // Unsupported opcode: one-cycle pulse, straight back to FETCH
    begin_txn(32'h0000007F);
    cyc("ill.fetch",  0, 1, 0, e_fetch(1));
    cyc("ill.decode", 0, 1, 0, e_decode(3'b000, 1));
    cyc("ill.refetch",0, 0, 0, e_fetch(0));
    end_txn("illegal");

    // Reset while a store is stalled: request dropped, fetch restarts after hold
    begin_txn(32'h0020A223);
    cyc("swr.fetch",  0, 1, 0, e_fetch(1));
    cyc("swr.decode", 0, 1, 0, e_decode(3'b001, 0));
    cyc("swr.memadr", 0, 1, 0, e_memadr(3'b001));
    cyc("swr.wrwait", 0, 0, 0, e_memwrite());
    cyc("swr.rst",    1, 0, 0, '0);
    cyc("swr.hold",   0, 1, 0, e_hold());
    cyc("swr.fetch2", 0, 1, 0, e_fetch(1));
    end_txn("sw.rst");

    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_bad++;
      $error("FAIL sb_drain: observed %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
